// File: rtl/peripheral_ahb3_spram_master_if.sv
// AHB3-Lite bus bundle between the SPRAM master and its slave (or interconnect).
// The master modport drives the address/control/write-data signals; the slave
// modport returns read data, ready and response.
interface peripheral_ahb3_spram_master_if #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
);

  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HRESP;

  modport master (
    output HSEL,
    output HADDR,
    output HWDATA,
    output HWRITE,
    output HSIZE,
    output HBURST,
    output HPROT,
    output HTRANS,
    output HMASTLOCK,
    input  HRDATA,
    input  HREADY,
    input  HRESP
  );

  modport slave (
    input  HSEL,
    input  HADDR,
    input  HWDATA,
    input  HWRITE,
    input  HSIZE,
    input  HBURST,
    input  HPROT,
    input  HTRANS,
    input  HMASTLOCK,
    output HRDATA,
    output HREADY,
    output HRESP
  );

endinterface

// File: rtl/peripheral_ahb3_spram_master.sv
// Single-outstanding AHB3-Lite initiator. Each accepted command becomes one
// SINGLE NONSEQ transfer; slave wait states and the two-cycle ERROR response
// are absorbed and a per-command ack/err status is returned. Misaligned
// commands are rejected locally without touching the bus.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command (rdy_o=1 unless the ack cycle is showing)
// ADDR  | NONSEQ address phase on the bus, waiting for HREADY
// DATA  | data phase, waiting for HREADY to complete (OKAY or ERROR)
// LERR  | misaligned command: ack_o/err_o visible for this one cycle
module peripheral_ahb3_spram_master #(
  parameter int         PLEN        = 8,
  parameter int         XLEN        = 32,
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic            HCLK,
  input  logic            HRESETn,

  input  logic            req_i,
  output logic            rdy_o,
  input  logic            we_i,
  input  logic [PLEN-1:0] addr_i,
  input  logic [2:0]      size_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ack_o,
  output logic            err_o,
  output logic [XLEN-1:0] rdata_o,

  peripheral_ahb3_spram_master_if.master ahb
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_LERR = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]      state_q,  state_d;
  logic [1:0]      htrans_q, htrans_d;
  logic            hsel_q,   hsel_d;
  logic [PLEN-1:0] haddr_q,  haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [2:0]      hsize_q,  hsize_d;
  logic [XLEN-1:0] hwdata_q, hwdata_d;
  logic [XLEN-1:0] wdata_q,  wdata_d;
  logic            ack_q,    ack_d;
  logic            err_q,    err_d;
  logic [XLEN-1:0] rdata_q,  rdata_d;

  logic [PLEN-1:0] align_mask;
  logic            misaligned;

  // Low address bits that must be zero for the requested transfer size.
  assign align_mask = ~({PLEN{1'b1}} << size_i);
  assign misaligned = |(addr_i & align_mask);

  // The ack cycle is kept out of rdy_o so a new command is only taken the
  // cycle after ack_o, identically for bus completions and local rejects.
  assign rdy_o = (state_q == ST_IDLE) && !ack_q;

  // Next-state and output-register computation for the command FSM.
  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    hsel_d   = hsel_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i && rdy_o) begin
          if (misaligned) begin
            // Rejected without bus activity; status shows while in LERR.
            state_d = ST_LERR;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
            hsel_d   = 1'b1;
            haddr_d  = addr_i;
            hwrite_d = we_i;
            hsize_d  = size_i;
            wdata_d  = wdata_i;
          end
        end
      end

      ST_ADDR: begin
        // Address-phase signals simply hold while the slave stalls.
        if (ahb.HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hsel_d   = 1'b0;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      ST_DATA: begin
        // First ERROR cycle (HRESP=1, HREADY=0) needs no action: HTRANS is
        // already IDLE, so completion just waits for the HREADY=1 cycle.
        if (ahb.HREADY) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          err_d   = ahb.HRESP;
          if (!hwrite_q && !ahb.HRESP) begin
            rdata_d = ahb.HRDATA;
          end
        end
      end

      ST_LERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
        hsel_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any command in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      hsel_q   <= 1'b0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      hsel_q   <= hsel_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

  assign ahb.HSEL      = hsel_q;
  assign ahb.HADDR     = haddr_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HSIZE     = hsize_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = HPROT_VALUE;
  assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_ahb3_spram_master.sv
// Bench for the AHB3 SPRAM master: a behavioural memory slave with
// programmable wait states / ERROR responses, and a command-level reference
// model (byte-array memory, latency formula, expected status).
module tb_peripheral_ahb3_spram_master;

  localparam int PLEN = 8;
  localparam int XLEN = 32;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic            req_i;
  logic            rdy_o;
  logic            we_i;
  logic [PLEN-1:0] addr_i;
  logic [2:0]      size_i;
  logic [XLEN-1:0] wdata_i;
  logic            ack_o;
  logic            err_o;
  logic [XLEN-1:0] rdata_o;

  peripheral_ahb3_spram_master_if #(.PLEN(PLEN), .XLEN(XLEN)) bus ();

  peripheral_ahb3_spram_master #(
    .PLEN(PLEN), .XLEN(XLEN), .HPROT_VALUE(4'b0011)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req_i   (req_i),
    .rdy_o   (rdy_o),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .size_i  (size_i),
    .wdata_i (wdata_i),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .rdata_o (rdata_o),
    .ahb     (bus.master)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus snapshot / monitor (values seen at each edge) -----
  logic [1:0]      s_htrans;
  logic            s_hsel;
  logic            s_hready;
  logic [XLEN-1:0] s_hwdata;
  int              ns_cnt  = 0;
  int              ack_cnt = 0;
  logic [PLEN-1:0] ns_addr;
  logic            ns_write;
  logic [2:0]      ns_size;

  always @(posedge HCLK) begin
    s_htrans = bus.HTRANS;
    s_hsel   = bus.HSEL;
    s_hready = bus.HREADY;
    s_hwdata = bus.HWDATA;
    if (ack_o === 1'b1) ack_cnt++;
    if (bus.HSEL === 1'b1 && bus.HTRANS === 2'b10 && bus.HREADY === 1'b1) begin
      ns_cnt++;
      ns_addr  = bus.HADDR;
      ns_write = bus.HWRITE;
      ns_size  = bus.HSIZE;
    end
  end

  // ---------------- behavioural SPRAM slave --------------------------------
  logic [7:0]      slv_mem [256];
  bit              dp_active = 0;
  bit              dp_write, dp_err, dp_errph;
  logic [PLEN-1:0] dp_addr;
  logic [2:0]      dp_size;
  int              dp_wait;
  int              cfg_wait = 0;
  bit              cfg_err  = 0;
  bit              cfg_hold = 0;
  logic [7:0]      sidx;

  always @(negedge HCLK) begin
    if (HRESETn !== 1'b1) begin
      dp_active = 0;
    end else if (s_hready === 1'b1) begin
      if (dp_active) begin
        if (dp_write && !dp_err) begin
          for (int k = 0; k < (1 << dp_size); k++) begin
            sidx = dp_addr + 8'(k);
            slv_mem[sidx] = s_hwdata[8*sidx[1:0] +: 8];
          end
        end
        dp_active = 0;
      end
      if (s_hsel === 1'b1 && s_htrans === 2'b10) begin
        dp_active = 1;
        dp_addr   = ns_addr;
        dp_write  = ns_write;
        dp_size   = ns_size;
        dp_wait   = cfg_wait;
        dp_err    = cfg_err;
        dp_errph  = 0;
      end
    end
    bus.HRDATA = $urandom;
    bus.HRESP  = 1'b0;
    if (dp_active) begin
      if (dp_wait > 0) begin
        bus.HREADY = 1'b0;
        dp_wait--;
      end else if (dp_err && !dp_errph) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        dp_errph   = 1;
      end else if (dp_err) begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b1;
      end else begin
        sidx = {dp_addr[7:2], 2'b00};
        bus.HREADY = 1'b1;
        bus.HRDATA = {slv_mem[sidx+8'd3], slv_mem[sidx+8'd2], slv_mem[sidx+8'd1], slv_mem[sidx]};
      end
    end else begin
      bus.HREADY = !cfg_hold;
    end
  end

  // ---------------- reference model ----------------------------------------
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rdata  = 32'h0;
  logic [31:0] exp_hwdata = 32'h0;

  task automatic do_cmd(input bit we, input logic [7:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int waits, input bit serr);
    int n, lat, ns0;
    bit mis, bad_rdy, bad_err;
    logic [7:0] a;
    mis = (int'(addr) % (1 << size)) != 0;
    lat = mis ? 1 : 3 + waits + (serr ? 1 : 0);

    @(negedge HCLK);
    n = 0;
    while (rdy_o !== 1'b1 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check("rdy_before_cmd", rdy_o, 1);
    cfg_wait = waits;
    cfg_err  = serr;
    req_i = 1'b1; we_i = we; addr_i = addr; size_i = size; wdata_i = wdata;
    ns0 = ns_cnt;

    @(posedge HCLK); #1;
    req_i = 1'b0;
    n = 1; bad_rdy = 0; bad_err = 0;
    while (ack_o !== 1'b1 && n < lat + 20) begin
      if (rdy_o !== 1'b0) bad_rdy = 1;
      if (err_o !== 1'b0) bad_err = 1;
      @(posedge HCLK); #1;
      n++;
    end

    if (!mis) begin
      if (we) begin
        exp_hwdata = wdata;
        if (!serr)
          for (int k = 0; k < (1 << size); k++) begin
            a = addr + 8'(k);
            ref_mem[a] = wdata[8*(int'(a) % 4) +: 8];
          end
      end else if (!serr) begin
        a = addr & 8'hFC;
        exp_rdata = {ref_mem[a+8'd3], ref_mem[a+8'd2], ref_mem[a+8'd1], ref_mem[a]};
      end
    end

    check("ack_latency", n, lat);
    check("err_with_ack", err_o, mis || serr);
    check("rdy_low_in_transfer", bad_rdy, 0);
    check("err_only_with_ack", bad_err, 0);
    check("rdata", rdata_o, exp_rdata);
    check("hwdata", bus.HWDATA, exp_hwdata);
    check("nonseq_count", ns_cnt - ns0, mis ? 0 : 1);
    if (!mis) begin
      check("haddr", ns_addr, addr);
      check("hwrite", ns_write, we);
      check("hsize", ns_size, size);
    end

    @(posedge HCLK); #1;
    check("ack_single_cycle", ack_o, 0);
    check("err_low_after", err_o, 0);
    check("rdy_after_ack", rdy_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack0;
    logic [7:0]  r_addr;
    logic [2:0]  r_size;
    logic [31:0] w0, w1;

    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    HRESETn = 1'b0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; size_i = 3'd0; wdata_i = '0;

    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", bus.HTRANS, 2'b00);
    check("rst_hsel", bus.HSEL, 0);
    check("rst_haddr", bus.HADDR, 0);
    check("rst_hwdata", bus.HWDATA, 0);
    check("rst_hwrite", bus.HWRITE, 0);
    check("rst_hsize", bus.HSIZE, 0);
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_rdy", rdy_o, 1);
    check("hburst", bus.HBURST, 3'b000);
    check("hprot", bus.HPROT, 4'b0011);
    check("hmastlock", bus.HMASTLOCK, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Directed: write, waited read, error read, misaligned write
    do_cmd(1, 8'h10, 3'd2, 32'hDEADBEEF, 0, 0);
    do_cmd(0, 8'h10, 3'd2, 32'h0, 2, 0);
    do_cmd(0, 8'h20, 3'd2, 32'h0, 0, 1);
    do_cmd(1, 8'h03, 3'd1, 32'h12345678, 0, 0);

    // Back-to-back writes then readback, plus sub-word writes
    w0 = $urandom; w1 = $urandom;
    do_cmd(1, 8'h00, 3'd2, w0, 0, 0);
    do_cmd(1, 8'h04, 3'd2, w1, 0, 0);
    do_cmd(0, 8'h00, 3'd2, 32'h0, 0, 0);
    do_cmd(0, 8'h04, 3'd2, 32'h0, 1, 0);
    do_cmd(1, 8'h05, 3'd0, 32'hA5A5A5A5, 0, 0);
    do_cmd(1, 8'h02, 3'd1, 32'hC3C3C3C3, 3, 0);
    do_cmd(0, 8'h04, 3'd2, 32'h0, 0, 0);
    do_cmd(0, 8'h00, 3'd2, 32'h0, 0, 0);
    do_cmd(1, 8'h08, 3'd2, 32'h11111111, 1, 1);
    do_cmd(0, 8'h08, 3'd2, 32'h0, 0, 0);

    // Reset while NONSEQ is stalled in the address phase
    @(negedge HCLK);
    cfg_hold = 1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'h40; size_i = 3'd2; wdata_i = 32'h55AA55AA;
    @(posedge HCLK); #1;
    req_i = 1'b0;
    check("stall_nonseq", bus.HTRANS, 2'b10);
    check("stall_hsel", bus.HSEL, 1);
    @(posedge HCLK); #1;
    check("stall_nonseq_held", bus.HTRANS, 2'b10);
    check("stall_haddr_held", bus.HADDR, 8'h40);
    check("stall_rdy", rdy_o, 0);
    ack0 = ack_cnt;
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("midrst_htrans", bus.HTRANS, 2'b00);
    check("midrst_hsel", bus.HSEL, 0);
    check("midrst_haddr", bus.HADDR, 0);
    repeat (2) @(negedge HCLK);
    cfg_hold = 0;
    HRESETn = 1'b1;
    exp_rdata  = 32'h0;
    exp_hwdata = 32'h0;
    repeat (5) @(posedge HCLK);
    #1;
    check("midrst_rdy", rdy_o, 1);
    check("midrst_no_ack", ack_cnt - ack0, 0);

    // Randomized commands against the reference model
    for (int i = 0; i < 60; i++) begin
      r_addr = 8'($urandom_range(0, 255));
      r_size = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0)
        r_addr = r_addr & ~(8'((1 << r_size) - 1));
      do_cmd($urandom_range(0, 1) == 1, r_addr, r_size, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
